// File: rtl/store_buffer.sv
// Per-strand store buffer: holds one line store per strand, issues pending stores to L2
// round-robin, and completes them on a matching L2 response with an L1 line update.
module store_buffer #(
    parameter logic [1:0] UNIT_ID = 2'd2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         request_i,
    input  logic [1:0]   strand_i,
    input  logic [31:0]  address_i,
    input  logic [511:0] data_i,
    input  logic [63:0]  mask_i,
    input  logic         synchronized_i,
    output logic         rollback_o,
    output logic [3:0]   resume_strands_o,
    output logic         store_update_o,
    output logic [4:0]   store_update_set_o,
    output logic         pci_valid,
    output logic [1:0]   pci_unit,
    output logic [1:0]   pci_strand,
    output logic [2:0]   pci_op,
    output logic [1:0]   pci_way,
    output logic [25:0]  pci_address,
    output logic [511:0] pci_data,
    output logic [63:0]  pci_mask,
    input  logic         pci_ack,
    input  logic         cpi_valid,
    input  logic [1:0]   cpi_unit,
    input  logic [1:0]   cpi_strand
);

    logic [3:0]   valid_q, valid_d;
    logic [3:0]   issued_q, issued_d;
    logic [3:0]   sync_q;
    logic [25:0]  line_q [4];
    logic [511:0] data_q [4];
    logic [63:0]  mask_q [4];
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic         lock_q, lock_d;
    logic [1:0]   sel_q, sel_d;
    logic         rollback_q, rollback_d;

    logic [3:0]   cand;
    logic         arb_found;
    logic [1:0]   arb_idx;
    logic [1:0]   scan_idx;
    logic [1:0]   sel;
    logic         grant;
    logic         resp_hit;
    logic         load;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^address_i[5:0];

    assign cand     = valid_q & ~issued_q;
    assign resp_hit = cpi_valid && (cpi_unit == UNIT_ID) &&
                      valid_q[cpi_strand] && issued_q[cpi_strand];
    // An entry freed by this cycle's response can be refilled at the same edge.
    assign load     = request_i &&
                      (!valid_q[strand_i] || (resp_hit && (cpi_strand == strand_i)));

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!arb_found && cand[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    // Once offered, the selection is held until the ack so the L2 request stays stable.
    assign sel       = lock_q ? sel_q : arb_idx;
    assign pci_valid = lock_q || arb_found;
    assign grant     = pci_valid && pci_ack;

    always_comb begin
        valid_d  = valid_q;
        issued_d = issued_q;
        if (resp_hit) begin
            valid_d[cpi_strand]  = 1'b0;
            issued_d[cpi_strand] = 1'b0;
        end
        if (grant) begin
            issued_d[sel] = 1'b1;
        end
        if (load) begin
            valid_d[strand_i]  = 1'b1;
            issued_d[strand_i] = 1'b0;
        end
        rr_ptr_d   = grant ? sel + 2'd1 : rr_ptr_q;
        lock_d     = pci_valid && !pci_ack;
        sel_d      = sel;
        rollback_d = request_i && !load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            issued_q   <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            sel_q      <= '0;
            rollback_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            issued_q   <= issued_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            sel_q      <= sel_d;
            rollback_q <= rollback_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            line_q[strand_i] <= address_i[31:6];
            data_q[strand_i] <= data_i;
            mask_q[strand_i] <= mask_i;
            sync_q[strand_i] <= synchronized_i;
        end
    end

    assign pci_unit    = UNIT_ID;
    assign pci_strand  = sel;
    assign pci_op      = sync_q[sel] ? 3'd5 : 3'd1;
    assign pci_way     = 2'd0;
    assign pci_address = line_q[sel];
    assign pci_data    = data_q[sel];
    assign pci_mask    = mask_q[sel];

    assign rollback_o         = rollback_q;
    assign resume_strands_o   = resp_hit ? (4'b0001 << cpi_strand) : 4'b0000;
    assign store_update_o     = resp_hit;
    assign store_update_set_o = resp_hit ? line_q[cpi_strand][4:0] : 5'd0;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, all checked against a
// per-strand reference model through expected-event queues drained by a negedge monitor.
module tb_store_buffer;

    localparam logic [1:0] UID = 2'd2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         request_i = 1'b0;
    logic [1:0]   strand_i = 2'd0;
    logic [31:0]  address_i = 32'd0;
    logic [511:0] data_i = '0;
    logic [63:0]  mask_i = '0;
    logic         synchronized_i = 1'b0;
    logic         rollback_o;
    logic [3:0]   resume_strands_o;
    logic         store_update_o;
    logic [4:0]   store_update_set_o;
    logic         pci_valid;
    logic [1:0]   pci_unit;
    logic [1:0]   pci_strand;
    logic [2:0]   pci_op;
    logic [1:0]   pci_way;
    logic [25:0]  pci_address;
    logic [511:0] pci_data;
    logic [63:0]  pci_mask;
    logic         pci_ack = 1'b0;
    logic         cpi_valid = 1'b0;
    logic [1:0]   cpi_unit = 2'd0;
    logic [1:0]   cpi_strand = 2'd0;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [1:0]   strand;
        logic [2:0]   op;
        logic [1:0]   unit;
        logic [1:0]   way;
        logic [25:0]  addr;
        logic [511:0] data;
        logic [63:0]  mask;
    } grant_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  resume;
        logic [4:0]  upd_set;
    } resume_t;

    grant_t      exp_grant_q[$];
    resume_t     exp_resume_q[$];
    logic [31:0] exp_rb_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cyc = 32'd0;

    // Reference model: one slot per strand plus the arbiter's pointer and held offer.
    bit           m_valid [4];
    bit           m_issued[4];
    bit           m_sync  [4];
    logic [25:0]  m_line  [4];
    logic [511:0] m_data  [4];
    logic [63:0]  m_mask  [4];
    int           m_ptr;
    int           m_offer;
    bit           exp_pv;
    int           exp_off;

    store_buffer #(.UNIT_ID(UID)) dut (
        .clk(clk), .reset(reset),
        .request_i(request_i), .strand_i(strand_i), .address_i(address_i),
        .data_i(data_i), .mask_i(mask_i), .synchronized_i(synchronized_i),
        .rollback_o(rollback_o), .resume_strands_o(resume_strands_o),
        .store_update_o(store_update_o), .store_update_set_o(store_update_set_o),
        .pci_valid(pci_valid), .pci_unit(pci_unit), .pci_strand(pci_strand),
        .pci_op(pci_op), .pci_way(pci_way), .pci_address(pci_address),
        .pci_data(pci_data), .pci_mask(pci_mask), .pci_ack(pci_ack),
        .cpi_valid(cpi_valid), .cpi_unit(cpi_unit), .cpi_strand(cpi_strand)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i]  = 1'b0;
            m_issued[i] = 1'b0;
        end
        m_ptr   = 0;
        m_offer = -1;
        exp_rb_q.delete();
    endtask

    // Evaluate one cycle from the driven inputs and pre-edge model state, then advance.
    task automatic model_cycle();
        int      off;
        bit      hit;
        bit      grant;
        grant_t  g;
        resume_t r;
        off = -1;
        if (m_offer >= 0) off = m_offer;
        else begin
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (m_ptr + k) % 4;
                if (off < 0 && m_valid[s] && !m_issued[s]) off = s;
            end
        end
        exp_pv  = (off >= 0);
        exp_off = off;

        hit = cpi_valid && (cpi_unit == UID) && m_valid[cpi_strand] && m_issued[cpi_strand];
        if (hit) begin
            r.cyc     = cyc;
            r.resume  = 4'b0001 << cpi_strand;
            r.upd_set = m_line[cpi_strand][4:0];
            exp_resume_q.push_back(r);
        end

        grant = exp_pv && pci_ack;
        if (grant) begin
            g.cyc    = cyc;
            g.strand = 2'(off);
            g.op     = m_sync[off] ? 3'd5 : 3'd1;
            g.unit   = UID;
            g.way    = 2'd0;
            g.addr   = m_line[off];
            g.data   = m_data[off];
            g.mask   = m_mask[off];
            exp_grant_q.push_back(g);
        end

        if (hit) begin
            m_valid[cpi_strand]  = 1'b0;
            m_issued[cpi_strand] = 1'b0;
        end
        if (grant) begin
            m_issued[off] = 1'b1;
            m_ptr         = (off + 1) % 4;
            m_offer       = -1;
        end else begin
            m_offer = off;
        end
        if (request_i) begin
            if (!m_valid[strand_i]) begin
                m_valid[strand_i]  = 1'b1;
                m_issued[strand_i] = 1'b0;
                m_line[strand_i]   = address_i[31:6];
                m_data[strand_i]   = data_i;
                m_mask[strand_i]   = mask_i;
                m_sync[strand_i]   = synchronized_i;
            end else begin
                exp_rb_q.push_back(cyc + 32'd1);
            end
        end
    endtask

    task automatic step(input bit req, input logic [1:0] st, input logic [31:0] addr,
                        input logic [63:0] m, input bit sy, input bit ack,
                        input bit cv, input logic [1:0] cu, input logic [1:0] cs);
        @(posedge clk);
        #1;
        request_i      = req;
        strand_i       = st;
        address_i      = addr;
        data_i         = rand_line();
        mask_i         = m;
        synchronized_i = sy;
        pci_ack        = ack;
        cpi_valid      = cv;
        cpi_unit       = cu;
        cpi_strand     = cs;
        model_cycle();
        #1;
        check("pci_valid", 512'(pci_valid), 512'(exp_pv));
        if (exp_pv) check("pci_offer_strand", 512'(pci_strand), 512'(exp_off));
    endtask

    task automatic idle(input bit ack);
        step(1'b0, 2'd0, 32'd0, 64'd0, 1'b0, ack, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic respond(input logic [1:0] cu, input logic [1:0] cs);
        step(1'b0, 2'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, cu, cs);
    endtask

    task automatic store(input logic [1:0] st, input logic [31:0] addr, input bit ack);
        step(1'b1, st, addr, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), ack,
             1'b0, 2'd0, 2'd0);
    endtask

    grant_t      mg;
    resume_t     mr;
    logic [31:0] mc;

    always @(negedge clk) begin
        if (pci_valid === 1'b1 && pci_ack === 1'b1) begin
            if (exp_grant_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL grant: strand %0d granted at cycle %0d, no grant expected",
                         pci_strand, cyc);
            end else begin
                mg = exp_grant_q.pop_front();
                check("grant_cycle", 512'(cyc), 512'(mg.cyc));
                check("grant_strand", 512'(pci_strand), 512'(mg.strand));
                check("grant_op", 512'(pci_op), 512'(mg.op));
                check("grant_unit", 512'(pci_unit), 512'(mg.unit));
                check("grant_way", 512'(pci_way), 512'(mg.way));
                check("grant_address", 512'(pci_address), 512'(mg.addr));
                check("grant_data", pci_data, mg.data);
                check("grant_mask", 512'(pci_mask), 512'(mg.mask));
            end
        end
        if (resume_strands_o != 4'b0000 || store_update_o != 1'b0) begin
            if (exp_resume_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resume: resume=%b store_update=%b at cycle %0d, none expected",
                         resume_strands_o, store_update_o, cyc);
            end else begin
                mr = exp_resume_q.pop_front();
                check("resume_cycle", 512'(cyc), 512'(mr.cyc));
                check("resume_strands", 512'(resume_strands_o), 512'(mr.resume));
                check("store_update", 512'(store_update_o), 512'(1'b1));
                check("store_update_set", 512'(store_update_set_o), 512'(mr.upd_set));
            end
        end
        if (rollback_o === 1'b1) begin
            if (exp_rb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rollback: asserted at cycle %0d, none expected", cyc);
            end else begin
                mc = exp_rb_q.pop_front();
                check("rollback_cycle", 512'(cyc), 512'(mc));
            end
        end
    end

    initial begin
        logic [31:0] a028;
        logic [31:0] a031;
        logic [1:0]  rr_order [3];
        int          iss[$];
        int          guard;
        bit          busy;

        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pci_valid", 512'(pci_valid), 512'(1'b0));
        check("reset_rollback", 512'(rollback_o), 512'(1'b0));
        check("reset_resume", 512'(resume_strands_o), 512'(4'b0000));
        check("reset_store_update", 512'(store_update_o), 512'(1'b0));
        check("reset_update_set", 512'(store_update_set_o), 512'(5'd0));
        @(posedge clk);
        #1 reset = 1'b0;

        // Round-robin from strand 0 with ack held high.
        rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd3;
        store(2'd0, $urandom(), 1'b0);
        store(2'd1, $urandom(), 1'b0);
        store(2'd3, $urandom(), 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("rr_grant_order", 512'(pci_strand), 512'(rr_order[i]));
        end
        idle(1'b1);
        respond(UID, 2'd0);
        respond(UID, 2'd1);
        respond(UID, 2'd3);

        // Single store from strand 1 at 0x1A40.
        a028 = 32'h0000_1A40;
        step(1'b1, 2'd1, a028, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        idle(1'b1);
        check("single_pci_valid", 512'(pci_valid), 512'(1'b1));
        check("single_pci_op", 512'(pci_op), 512'(3'd1));
        check("single_pci_strand", 512'(pci_strand), 512'(2'd1));
        check("single_pci_address", 512'(pci_address), 512'(a028[31:6]));
        check("single_pci_mask", 512'(pci_mask), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        respond(UID, 2'd1);
        check("single_resume", 512'(resume_strands_o), 512'(4'b0010));
        check("single_store_update", 512'(store_update_o), 512'(1'b1));
        check("single_update_set", 512'(store_update_set_o), 512'(a028[10:6]));

        // Buffer full: second store from strand 2 must roll back, one issue only.
        store(2'd2, $urandom(), 1'b0);
        store(2'd2, $urandom(), 1'b1);
        idle(1'b1);
        check("full_rollback_high", 512'(rollback_o), 512'(1'b1));
        idle(1'b1);
        check("full_rollback_low", 512'(rollback_o), 512'(1'b0));
        respond(UID, 2'd2);

        // Free and refill strand 0 in the same cycle.
        store(2'd0, $urandom(), 1'b0);
        idle(1'b1);
        a031 = $urandom();
        step(1'b1, 2'd0, a031, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b1, UID, 2'd0);
        idle(1'b1);
        check("refill_no_rollback", 512'(rollback_o), 512'(1'b0));
        check("refill_pci_strand", 512'(pci_strand), 512'(2'd0));
        check("refill_pci_address", 512'(pci_address), 512'(a031[31:6]));
        respond(UID, 2'd0);

        // Stray responses: wrong unit, then an empty entry.
        store(2'd0, $urandom(), 1'b0);
        idle(1'b1);
        respond(2'd1, 2'd0);
        check("stray_unit_resume", 512'(resume_strands_o), 512'(4'b0000));
        check("stray_unit_update", 512'(store_update_o), 512'(1'b0));
        respond(UID, 2'd3);
        check("stray_empty_resume", 512'(resume_strands_o), 512'(4'b0000));
        check("stray_empty_update", 512'(store_update_o), 512'(1'b0));
        respond(UID, 2'd0);
        check("stray_then_real_resume", 512'(resume_strands_o), 512'(4'b0001));

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int r;
            bit cv;
            logic [1:0] cu;
            logic [1:0] cs;
            iss.delete();
            for (int s = 0; s < 4; s++) if (m_valid[s] && m_issued[s]) iss.push_back(s);
            r  = $urandom_range(0, 99);
            cv = 1'b0;
            cu = UID;
            cs = 2'($urandom_range(0, 3));
            if (r < 45 && iss.size() > 0) begin
                cv = 1'b1;
                cs = 2'(iss[$urandom_range(0, iss.size() - 1)]);
            end else if (r < 60) begin
                cv = 1'b1;
                cu = 2'($urandom_range(0, 3));
            end
            step(1'($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)), $urandom(),
                 {$urandom(), $urandom()}, 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 99) < 60), cv, cu, cs);
        end

        // Drain everything still held.
        guard = 0;
        busy  = 1'b1;
        while (busy && guard < 100) begin
            iss.delete();
            for (int s = 0; s < 4; s++) if (m_valid[s] && m_issued[s]) iss.push_back(s);
            if (iss.size() > 0)
                step(1'b0, 2'd0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b1, UID, 2'(iss[0]));
            else
                idle(1'b1);
            busy = 1'b0;
            for (int s = 0; s < 4; s++) if (m_valid[s]) busy = 1'b1;
            guard++;
        end

        // Reset with three stores pending at L2 request port.
        store(2'd0, $urandom(), 1'b0);
        store(2'd1, $urandom(), 1'b0);
        store(2'd2, $urandom(), 1'b0);
        idle(1'b0);
        check("pre_reset_pci_valid", 512'(pci_valid), 512'(1'b1));
        #1 reset = 1'b1;
        #1;
        check("async_reset_pci_valid", 512'(pci_valid), 512'(1'b0));
        check("async_reset_rollback", 512'(rollback_o), 512'(1'b0));
        check("async_reset_update_set", 512'(store_update_set_o), 512'(5'd0));
        model_reset();
        pci_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            respond(UID, 2'(s));
            check("post_reset_resume", 512'(resume_strands_o), 512'(4'b0000));
            check("post_reset_update", 512'(store_update_o), 512'(1'b0));
        end

        repeat (3) idle(1'b0);
        check("grant_queue_left", 512'(exp_grant_q.size()), 512'(0));
        check("resume_queue_left", 512'(exp_resume_q.size()), 512'(0));
        check("rollback_queue_left", 512'(exp_rb_q.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
